// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional JAL target prediction is enabled with the FETCH_JAL_PREDICT_EN macro.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [6:0]  OPC_JAL     = 7'b1101111;
    localparam logic [31:0] INST_BUBBLE = 32'h0000_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;

    // RV32 J-type immediate, sign-extended; bit 0 is always zero.
    function automatic logic [31:0] jal_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-fetch-address selection: redirect, JAL target, or sequential step.
// JAL target selection exists only when FETCH_JAL_PREDICT_EN is defined.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [31:0] cur_pc,
`ifdef FETCH_JAL_PREDICT_EN
    input  logic [31:0] cur_inst,
`endif
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = cur_pc + PC_STEP;
`ifdef FETCH_JAL_PREDICT_EN
        if (cur_inst[6:0] == OPC_JAL) begin
            next_pc = cur_pc + jal_imm(cur_inst);
        end
`endif
        // Redirect targets are forced to word alignment.
        if (redirect) begin
            next_pc = redirect_pc & ~32'h3;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, one-entry hold buffer for stalls,
// and wrong-path response discard after redirect. JAL prediction: FETCH_JAL_PREDICT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_encoding,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic        flush,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_FETCH   = ST_FETCH;
    localparam logic [1:0] S_HOLD    = ST_HOLD;
    localparam logic [1:0] S_DISCARD = ST_DISCARD;

    // imem handshake: imem_req is the valid, imem_ack the completion. Once raised,
    // imem_req and imem_addr stay put until the cycle imem_ack=1; the word on
    // imem_rdata is only meaningful in that cycle. At most one request is in flight.

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] discard_addr;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    logic [31:0] src_inst;
    logic [31:0] src_pc;
    logic [31:0] next_pc;
    logic        deliver;

    assign flush     = redirect;
    assign state_dbg = state;
    assign imem_req  = !rst && (state != S_HOLD);
    assign imem_addr = (state == S_DISCARD) ? discard_addr : fetch_pc;

    assign src_inst = (state == S_HOLD) ? hold_inst : imem_rdata;
    assign src_pc   = (state == S_HOLD) ? hold_pc   : fetch_pc;
    assign deliver  = !redirect && !stall &&
                      (((state == S_FETCH) && imem_ack) || (state == S_HOLD));

    fetch_next_pc u_next_pc (
        .cur_pc      (src_pc),
`ifdef FETCH_JAL_PREDICT_EN
        .cur_inst    (src_inst),
`endif
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            fetch_pc      <= RESET_PC & ~32'h3;
            discard_addr  <= 32'h0;
            hold_inst     <= 32'h0;
            hold_pc       <= 32'h0;
            inst_encoding <= INST_BUBBLE;
            pc            <= 32'h0;
            inst_valid    <= 1'b0;
        end else if (redirect) begin
            fetch_pc      <= next_pc;
            hold_inst     <= 32'h0;
            hold_pc       <= 32'h0;
            inst_encoding <= INST_BUBBLE;
            inst_valid    <= 1'b0;
            // An un-acked request must still be drained before fetching the new path.
            if ((state != S_HOLD) && !imem_ack) begin
                state <= S_DISCARD;
                if (state == S_FETCH) begin
                    discard_addr <= fetch_pc;
                end
            end else begin
                state <= S_FETCH;
            end
        end else begin
            if (deliver) begin
                inst_encoding <= src_inst;
                pc            <= src_pc;
                inst_valid    <= 1'b1;
                fetch_pc      <= next_pc;
            end else if (!stall) begin
                inst_encoding <= INST_BUBBLE;
                inst_valid    <= 1'b0;
            end

            case (state)
                S_FETCH: begin
                    if (imem_ack && stall) begin
                        hold_inst <= imem_rdata;
                        hold_pc   <= fetch_pc;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        state <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
